// File: rtl/bch_encoder_reg.sv
// Systematic BCH(15,7) encoder, g(x) = x^8+x^7+x^6+x^4+1, for the write path.
// Latency: one cycle from an accepted message to a registered codeword.
// Backpressure: none; one message per cycle, and the codeword holds while idle.
module bch_encoder_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [6:0]  message,
  output logic        out_valid,
  output logic [14:0] codeword
);

  logic [7:0] parity;

  // Each parity bit is the unrolled remainder of m(x)*x^8 mod g(x).
  always_comb begin
    parity    = 8'h00;
    parity[7] = message[0] ^ message[2] ^ message[6];
    parity[6] = message[0] ^ message[1] ^ message[2] ^ message[5] ^ message[6];
    parity[5] = message[1] ^ message[2] ^ message[4] ^ message[5] ^ message[6];
    parity[4] = message[0] ^ message[1] ^ message[3] ^ message[4] ^ message[5];
    parity[3] = message[3] ^ message[4] ^ message[6];
    parity[2] = message[2] ^ message[3] ^ message[5];
    parity[1] = message[1] ^ message[2] ^ message[4];
    parity[0] = message[0] ^ message[1] ^ message[3];
  end

  // Register data and parity together. Reset has priority and drops any message offered in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      codeword  <= 15'h0000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        codeword <= {message, parity};
      end
    end
  end

endmodule

// File: tb/tb_bch_encoder_reg.sv
// Self-checking bench for bch_encoder_reg: directed vectors, exhaustive sweep, random idle traffic.
// The reference encodes by GF(2) long division of m(x)*x^8 by g(x).
// No backpressure on the DUT, so every step is exactly one clock.
module tb_bch_encoder_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [6:0]  message;
  logic        out_valid;
  logic [14:0] codeword;

  int total = 0;
  int bad   = 0;

  logic        exp_vld;
  logic [14:0] exp_cw;

  bch_encoder_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .message   (message),
    .out_valid (out_valid),
    .codeword  (codeword)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of an arbitrary 15-bit polynomial modulo g(x) = 1_1101_0001.
  function automatic logic [7:0] poly_rem(input logic [14:0] c);
    logic [14:0] r;
    r = c;
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) r = r ^ (15'h01D1 << (i - 8));
    end
    return r[7:0];
  endfunction

  function automatic logic [14:0] ref_encode(input logic [6:0] m);
    return {m, poly_rem({m, 8'h00})};
  endfunction

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then sample just after the edge.
  task automatic step(input logic r, input logic v, input logic [6:0] m);
    rst      = r;
    in_valid = v;
    message  = m;
    @(posedge clk);
    #1;
    if (r) begin
      exp_vld = 1'b0;
      exp_cw  = 15'h0000;
    end else begin
      exp_vld = v;
      if (v) exp_cw = ref_encode(m);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_vld"}, {14'h0, out_valid}, {14'h0, exp_vld});
    chk({tag, "_cw"},  codeword, exp_cw);
  endtask

  logic [6:0]  vec_m  [0:17];
  logic [14:0] vec_cw [0:17];

  initial begin
    vec_m[0]  = 7'b1101100; vec_cw[0]  = 15'b110110001100111;
    vec_m[1]  = 7'b1110110; vec_cw[1]  = 15'b111011000110011;
    vec_m[2]  = 7'b1001111; vec_cw[2]  = 15'b100111110110001;
    vec_m[3]  = 7'b0001110; vec_cw[3]  = 15'b000111010001000;
    vec_m[4]  = 7'b0111110; vec_cw[4]  = 15'b011111011000110;
    vec_m[5]  = 7'b1010000; vec_cw[5]  = 15'b101000011010010;
    vec_m[6]  = 7'b1101000; vec_cw[6]  = 15'b110100010000001;
    vec_m[7]  = 7'b1100011; vec_cw[7]  = 15'b110001100111110;
    vec_m[8]  = 7'b1011000; vec_cw[8]  = 15'b101100011001111;
    vec_m[9]  = 7'b1010101; vec_cw[9]  = 15'b101010111100101;
    vec_m[10] = 7'b1111000; vec_cw[10] = 15'b111100010111011;
    vec_m[11] = 7'b1010100; vec_cw[11] = 15'b101010000110100;
    vec_m[12] = 7'b0100111; vec_cw[12] = 15'b010011100110000;
    vec_m[13] = 7'b1011010; vec_cw[13] = 15'b101101010111100;
    vec_m[14] = 7'b0111010; vec_cw[14] = 15'b011101000100000;
    vec_m[15] = 7'b0101110; vec_cw[15] = 15'b010111011111100;
    vec_m[16] = 7'b0010111; vec_cw[16] = 15'b001011101111110;
    vec_m[17] = 7'b0001010; vec_cw[17] = 15'b000101001101110;

    exp_vld = 1'b0;
    exp_cw  = 15'h0000;
    rst = 1'b1; in_valid = 1'b1; message = 7'b1101100;

    // Reset held for two cycles with a live message: it must be dropped.
    step(1'b1, 1'b1, 7'b1101100);
    chk_model("reset1");
    step(1'b1, 1'b1, 7'b1101100);
    chk_model("reset2");
    step(1'b0, 1'b0, 7'b1101100);
    chk_model("release");

    // Single encodes, each followed by an idle cycle.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, vec_m[i]);
      chk("single_cw", codeword, vec_cw[i]);
      chk_model("single");
      step(1'b0, 1'b0, 7'h00);
      chk_model("single_idle");
    end

    // Back-to-back stream: valid must stay high every cycle.
    for (int i = 4; i < 12; i++) begin
      step(1'b0, 1'b1, vec_m[i]);
      chk("stream_cw", codeword, vec_cw[i]);
      chk("stream_vld", {14'h0, out_valid}, 15'h0001);
    end
    step(1'b0, 1'b0, 7'h00);
    chk_model("stream_end");

    // Further vectors, including the 0001010 word sent twice with a gap.
    for (int i = 12; i < 18; i++) begin
      step(1'b0, 1'b1, vec_m[i]);
      chk("more_cw", codeword, vec_cw[i]);
      chk_model("more");
    end
    step(1'b0, 1'b0, 7'h00);
    chk_model("gap");
    step(1'b0, 1'b1, vec_m[17]);
    chk("repeat_cw", codeword, vec_cw[17]);

    // Idle with random data: codeword holds, valid stays low.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 7'($urandom));
      chk("hold_cw", codeword, vec_cw[17]);
      chk("hold_vld", {14'h0, out_valid}, 15'h0000);
    end

    // All 128 messages against the division model, plus divisibility by g(x).
    for (int i = 0; i < 128; i++) begin
      step(1'b0, 1'b1, 7'(i));
      chk_model("exh");
      chk("exh_div", {7'h0, poly_rem(codeword)}, 15'h0000);
    end
    step(1'b0, 1'b1, 7'h00);
    chk("zero_word", codeword, 15'h0000);

    // Linearity spot checks using random pairs.
    for (int i = 0; i < 8; i++) begin
      logic [6:0] a, b;
      a = 7'($urandom);
      b = 7'($urandom);
      step(1'b0, 1'b1, a ^ b);
      chk("linear", codeword, ref_encode(a) ^ ref_encode(b));
    end

    // Reset mid-stream: the sample taken with rst is discarded.
    step(1'b0, 1'b1, 7'b1010101);
    chk_model("mid_pre");
    step(1'b1, 1'b1, 7'b0110011);
    chk_model("mid_rst");
    step(1'b0, 1'b0, 7'b0110011);
    chk_model("mid_after");
    step(1'b0, 1'b1, 7'b0110011);
    chk_model("mid_resume");

    // Random traffic mixing idle cycles, valid messages and occasional resets.
    for (int i = 0; i < 200; i++) begin
      logic r, v;
      r = ($urandom_range(0, 19) == 0);
      v = $urandom_range(0, 1) == 1;
      step(r, v, 7'($urandom));
      chk_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
